// File: rtl/cache_pkg.sv
// Shared types and helpers for the L2 lookup controller.
// Holds the controller state enum, default geometry and the tree pseudo-LRU
// victim/touch functions. Trees use heap order: node 0 is the root and the
// children of node n are 2n+1 and 2n+2. A node bit of 0 means the victim lies
// in the lower half below that node.
package cache_pkg;

  localparam int unsigned DefWays      = 8;
  localparam int unsigned DefTagBits   = 10;
  localparam int unsigned DefIndexBits = 6;

  // Helpers work on the widest supported tree; callers pass the real depth.
  localparam int unsigned MaxLevels = 6;
  localparam int unsigned MaxWays   = 2 ** MaxLevels;

  typedef logic [MaxWays-2:0]   plru_tree_t;
  typedef logic [MaxLevels-1:0] plru_way_t;

  typedef enum logic [2:0] {
    StIdle,
    StLookup,
    StCompare,
    StMissReq,
    StFill,
    StRespond
  } state_e;

  // Walk from the root following the node bits; the path spells the victim.
  function automatic plru_way_t plru_victim(input plru_tree_t tree, input int unsigned levels);
    plru_way_t         way;
    logic [MaxLevels-1:0] node;
    logic              b;
    way  = '0;
    node = '0;
    for (int unsigned lvl = 0; lvl < MaxLevels; lvl++) begin
      if (lvl < levels) begin
        b    = tree[node];
        way  = {way[MaxLevels-2:0], b};
        node = {node[MaxLevels-2:0], 1'b0} + {{(MaxLevels-1){1'b0}}, 1'b1}
             + {{(MaxLevels-1){1'b0}}, b};
      end
    end
    return way;
  endfunction

  // Every node on the path to way points away from it afterwards.
  function automatic plru_tree_t plru_touch(input plru_tree_t tree, input plru_way_t way,
                                            input int unsigned levels);
    plru_tree_t           t;
    plru_way_t            w;
    logic [MaxLevels-1:0] node;
    logic                 b;
    t    = tree;
    // Left-align the used way bits so the path bit is always the MSB.
    w    = way << (MaxLevels - levels);
    node = '0;
    for (int unsigned lvl = 0; lvl < MaxLevels; lvl++) begin
      if (lvl < levels) begin
        b       = w[MaxLevels-1];
        w       = w << 1;
        t[node] = ~b;
        node    = {node[MaxLevels-2:0], 1'b0} + {{(MaxLevels-1){1'b0}}, 1'b1}
                + {{(MaxLevels-1){1'b0}}, b};
      end
    end
    return t;
  endfunction

endpackage

// File: rtl/cache_lookup_ctrl_plru_tree.sv
// plru_tree: per-set pseudo-LRU tree storage.
// Ports: clk, rst_n (async active-low, clears every tree so victim is way 0),
// index (set being read/updated), victim (PLRU victim of that set, decoded
// from storage), touch_en/touch_way (mark touch_way most recently used).
module plru_tree
  import cache_pkg::*;
#(
  parameter int unsigned Ways      = DefWays,
  parameter int unsigned IndexBits = DefIndexBits,
  parameter int unsigned WayBits   = $clog2(Ways)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [IndexBits-1:0] index,
  output logic [WayBits-1:0]   victim,
  input  logic                 touch_en,
  input  logic [WayBits-1:0]   touch_way
);

  localparam int unsigned Sets = 2 ** IndexBits;

  logic [Ways-2:0] tree_q [Sets];
  plru_tree_t      cur_tree;
  plru_tree_t      next_tree;
  plru_way_t       victim_full;

  assign cur_tree    = plru_tree_t'(tree_q[index]);
  assign victim_full = plru_victim(cur_tree, WayBits);
  assign victim      = victim_full[WayBits-1:0];
  assign next_tree   = plru_touch(cur_tree, plru_way_t'(touch_way), WayBits);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < Sets; i++) tree_q[i] <= '0;
    end else if (touch_en) begin
      tree_q[index] <= next_tree[Ways-2:0];
    end
  end

endmodule

// File: rtl/cache_lookup_ctrl.sv
// cache_lookup_ctrl: sequences one L2 lookup at a time.
// Request port (reqValid/reqAddr/reqReady), response strobe (rspValid/rspHit/
// rspWay), tag/valid array control (arrRead/arrWrite/arrIndex/arrWay/arrTag),
// hit detector inputs (validBits/hdHit/hdWay) and memory fill handshake
// (memReq/memAddr/memAck). Outputs decode only from registered state.
module cache_lookup_ctrl
  import cache_pkg::*;
#(
  parameter int unsigned ways      = DefWays,
  parameter int unsigned tagBits   = DefTagBits,
  parameter int unsigned indexBits = DefIndexBits,
  parameter int unsigned wayBits   = $clog2(ways)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         reqValid,
  input  logic [tagBits+indexBits-1:0] reqAddr,
  output logic                         reqReady,
  output logic                         rspValid,
  output logic                         rspHit,
  output logic [wayBits-1:0]           rspWay,
  output logic                         arrRead,
  output logic                         arrWrite,
  output logic [indexBits-1:0]         arrIndex,
  output logic [wayBits-1:0]           arrWay,
  output logic [tagBits-1:0]           arrTag,
  input  logic [ways-1:0]              validBits,
  input  logic                         hdHit,
  input  logic [wayBits-1:0]           hdWay,
  output logic                         memReq,
  output logic [tagBits+indexBits-1:0] memAddr,
  input  logic                         memAck
);

  localparam int unsigned AddrBits = tagBits + indexBits;

  state_e               state_q, state_d;
  logic [AddrBits-1:0]  addr_q, addr_d;
  logic [wayBits-1:0]   way_q, way_d;
  logic                 hit_q, hit_d;
  logic                 touch_en;
  logic [wayBits-1:0]   touch_way;
  logic [wayBits-1:0]   victim_plru;
  logic                 inv_found;
  logic [wayBits-1:0]   inv_way;
  logic [ways-1:0]      vscan;

  plru_tree #(
    .Ways      (ways),
    .IndexBits (indexBits),
    .WayBits   (wayBits)
  ) u_plru (
    .clk       (clk),
    .rst_n     (rst_n),
    .index     (addr_q[indexBits-1:0]),
    .victim    (victim_plru),
    .touch_en  (touch_en),
    .touch_way (touch_way)
  );

  // Lowest-numbered invalid way; an empty slot always beats PLRU.
  always_comb begin
    inv_found = 1'b0;
    inv_way   = '0;
    vscan     = validBits;
    for (int unsigned i = 0; i < ways; i++) begin
      if (!vscan[0] && !inv_found) begin
        inv_found = 1'b1;
        inv_way   = wayBits'(i);
      end
      vscan = vscan >> 1;
    end
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    way_d     = way_q;
    hit_d     = hit_q;
    touch_en  = 1'b0;
    touch_way = way_q;
    unique case (state_q)
      StIdle: begin
        if (reqValid) begin
          addr_d  = reqAddr;
          state_d = StLookup;
        end
      end
      StLookup:  state_d = StCompare;
      StCompare: begin
        if (hdHit) begin
          hit_d     = 1'b1;
          way_d     = hdWay;
          touch_en  = 1'b1;
          touch_way = hdWay;
          state_d   = StRespond;
        end else begin
          hit_d   = 1'b0;
          way_d   = inv_found ? inv_way : victim_plru;
          state_d = StMissReq;
        end
      end
      StMissReq: begin
        if (memAck) state_d = StFill;
      end
      StFill: begin
        touch_en = 1'b1;
        state_d  = StRespond;
      end
      StRespond: state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      addr_q  <= '0;
      way_q   <= '0;
      hit_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      way_q   <= way_d;
      hit_q   <= hit_d;
    end
  end

  assign reqReady = (state_q == StIdle);
  assign arrRead  = (state_q == StLookup);
  assign arrWrite = (state_q == StFill);
  assign memReq   = (state_q == StMissReq);
  assign rspValid = (state_q == StRespond);
  assign rspHit   = rspValid & hit_q;
  assign rspWay   = rspValid ? way_q : '0;
  assign arrIndex = addr_q[indexBits-1:0];
  assign arrTag   = addr_q[AddrBits-1:indexBits];
  assign arrWay   = way_q;
  assign memAddr  = addr_q;

endmodule
